regfile_dump: RTL and testbench

REGFILE_DUMP -- requirements
Module: regfile_dump

---
 rtl/regfile_dump_if.sv | 10 +
 rtl/regfile_dump.sv | 117 +++++++++++
 tb/tb_regfile_dump.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_if.sv
// Output word stream of the register dump: one indexed 32-bit word per valid/ready transfer.
interface regfile_dump_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_idx;

    modport master (output out_valid, output out_data, output out_idx, input out_ready);
    modport slave  (input out_valid, input out_data, input out_idx, output out_ready);
endinterface

// File: rtl/regfile_dump.sv
// Walks a 2-read-port register file in ascending pairs and streams every register out with a running XOR.
// Latency: 3 cycles per pair with out_ready high; words are held while out_ready is low.
module regfile_dump #(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start,
    output logic [4:0]            rsel1,
    output logic [4:0]            rsel2,
    input  logic [31:0]           rdat1,
    input  logic [31:0]           rdat2,
    regfile_dump_if.master        out,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           checksum
);

    typedef enum logic [2:0] {IDLE, READ, SEND0, SEND1, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  ptr, ptr_nxt;
    logic [31:0] buf0, buf0_nxt;
    logic [31:0] buf1, buf1_nxt;
    logic [31:0] checksum_nxt;
    logic [4:0]  ptr_p1;
    logic        ptr_last;

    assign ptr_p1   = ptr + 5'd1;
    assign ptr_last = (ptr == 5'd31);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            ptr      <= 5'd0;
            buf0     <= 32'd0;
            buf1     <= 32'd0;
            checksum <= 32'd0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            buf0     <= buf0_nxt;
            buf1     <= buf1_nxt;
            checksum <= checksum_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        buf0_nxt      = buf0;
        buf1_nxt      = buf1;
        checksum_nxt  = checksum;
        rsel1         = 5'd0;
        rsel2         = 5'd0;
        out.out_valid = 1'b0;
        out.out_data  = 32'd0;
        out.out_idx   = 5'd0;

        // Selects stay on the pair being sent so the register file view is stable across the whole pair.
        if (state == READ || state == SEND0 || state == SEND1) begin
            rsel1 = ptr;
            rsel2 = ptr_last ? 5'd0 : ptr_p1;
        end

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt    = READ;
                    ptr_nxt      = SKIP_ZERO ? 5'd1 : 5'd0;
                    checksum_nxt = 32'd0;
                end
            end
            READ: begin
                buf0_nxt = rdat1;
                if (!ptr_last) begin
                    buf1_nxt = rdat2;
                end
                state_nxt = SEND0;
            end
            SEND0: begin
                out.out_valid = 1'b1;
                out.out_data  = buf0;
                out.out_idx   = ptr;
                if (out.out_ready) begin
                    checksum_nxt = checksum ^ buf0;
                    state_nxt    = ptr_last ? DONE : SEND1;
                end
            end
            SEND1: begin
                out.out_valid = 1'b1;
                out.out_data  = buf1;
                out.out_idx   = ptr_p1;
                if (out.out_ready) begin
                    checksum_nxt = checksum ^ buf1;
                    // The final pair ends at 31; leave ptr alone rather than wrap to 0.
                    if (ptr_p1 == 5'd31) begin
                        state_nxt = DONE;
                    end else begin
                        ptr_nxt   = ptr + 5'd2;
                        state_nxt = READ;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: full dumps, SKIP_ZERO, stall hold, ignored restarts, reset mid-dump.
module tb_regfile_dump;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_rst0, n_rst1, start0, start1;
    logic [4:0]  rsel1_0, rsel2_0, rsel1_1, rsel2_1;
    logic [31:0] rdat1_0, rdat2_0, rdat1_1, rdat2_1;
    logic        busy0, done0, busy1, done1;
    logic [31:0] csum0, csum1;
    logic [31:0] r [32];

    int checks = 0;
    int errors = 0;

    regfile_dump_if if0 ();
    regfile_dump_if if1 ();

    assign rdat1_0 = r[rsel1_0];
    assign rdat2_0 = r[rsel2_0];
    assign rdat1_1 = r[rsel1_1];
    assign rdat2_1 = r[rsel2_1];

    regfile_dump #(.SKIP_ZERO(1'b0)) dut0 (
        .clk(clk), .n_rst(n_rst0), .start(start0),
        .rsel1(rsel1_0), .rsel2(rsel2_0), .rdat1(rdat1_0), .rdat2(rdat2_0),
        .out(if0), .busy(busy0), .done(done0), .checksum(csum0)
    );

    regfile_dump #(.SKIP_ZERO(1'b1)) dut1 (
        .clk(clk), .n_rst(n_rst1), .start(start1),
        .rsel1(rsel1_1), .rsel2(rsel2_1), .rdat1(rdat1_1), .rdat2(rdat2_1),
        .out(if1), .busy(busy1), .done(done1), .checksum(csum1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle0(input string tag);
        check({tag, "_valid"}, {31'd0, if0.out_valid}, 32'd0);
        check({tag, "_data"}, if0.out_data, 32'd0);
        check({tag, "_idx"}, {27'd0, if0.out_idx}, 32'd0);
        check({tag, "_rsel1"}, {27'd0, rsel1_0}, 32'd0);
        check({tag, "_rsel2"}, {27'd0, rsel2_0}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy0}, 32'd0);
        check({tag, "_done"}, {31'd0, done0}, 32'd0);
        check({tag, "_csum"}, csum0, 32'd0);
    endtask

    // One dump on dut0, sampled at negedges; cycle 0 is the cycle start is presented.
    task automatic run_dump0(input int stall_idx, input bit restart, input int abort_idx,
                             input int exp_done_cyc);
        int          exp_idx   = 0;
        int          stall_cnt = 0;
        int          nxfer     = 0;
        int          ndone     = 0;
        logic [31:0] model     = 32'd0;
        bit          aborted   = 1'b0;
        @(negedge clk);
        start0 = 1'b1;
        if0.out_ready = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 70 && !aborted; cyc++) begin
            @(negedge clk);
            start0 = restart && (cyc == 10 || done0);
            if (abort_idx >= 0 && if0.out_valid && if0.out_idx == abort_idx[4:0]) begin
                n_rst0 = 1'b0;
                #1;
                check_idle0("abort");
                aborted = 1'b1;
            end else begin
                if (stall_idx >= 0 && stall_cnt < 5 &&
                    (stall_cnt > 0 || (if0.out_valid && if0.out_idx == stall_idx[4:0]))) begin
                    if0.out_ready = 1'b0;
                    stall_cnt++;
                    check("stall_valid", {31'd0, if0.out_valid}, 32'd1);
                    check("stall_idx", {27'd0, if0.out_idx}, stall_idx);
                    check("stall_data", if0.out_data, r[stall_idx]);
                end else begin
                    if0.out_ready = 1'b1;
                end
                if (if0.out_valid && if0.out_ready) begin
                    check("xfer_idx", {27'd0, if0.out_idx}, exp_idx);
                    check("xfer_data", if0.out_data, r[exp_idx]);
                    model ^= r[exp_idx];
                    exp_idx++;
                    nxfer++;
                end
                if (exp_done_cyc > 0) begin
                    check("done_cycle", {31'd0, done0}, {31'd0, cyc == exp_done_cyc});
                end
                ndone += int'(done0);
            end
        end
        start0 = 1'b0;
        if0.out_ready = 1'b1;
        if (!aborted) begin
            check("xfer_count", nxfer, 32);
            check("done_count", ndone, 1);
            check("checksum", csum0, model);
            check("end_busy", {31'd0, busy0}, 32'd0);
            check("end_valid", {31'd0, if0.out_valid}, 32'd0);
        end
    endtask

    initial begin
        int          exp_idx;
        int          nxfer;
        logic [31:0] model;

        for (int i = 0; i < 32; i++) r[i] = 32'(i) * 32'h01010101;
        n_rst0 = 1'b0;
        n_rst1 = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        if0.out_ready = 1'b1;
        if1.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_idle0("reset");
        check("reset1_valid", {31'd0, if1.out_valid}, 32'd0);
        check("reset1_busy", {31'd0, busy1}, 32'd0);
        n_rst0 = 1'b1;
        n_rst1 = 1'b1;
        repeat (2) @(negedge clk);

        // Plain dump, index 0..31
        run_dump0(-1, 1'b0, -1, 49);
        check("dump_csum_zero", csum0, 32'h0000_0000);

        // SKIP_ZERO dump on dut1, index 1..31, last word sent alone
        exp_idx = 1;
        nxfer   = 0;
        model   = 32'd0;
        start1  = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (if1.out_valid) begin
                check("skip_idx", {27'd0, if1.out_idx}, exp_idx);
                check("skip_data", if1.out_data, r[exp_idx]);
                if (if1.out_idx == 5'd31) begin
                    check("skip_last_rsel1", {27'd0, rsel1_1}, 32'd31);
                    check("skip_last_rsel2", {27'd0, rsel2_1}, 32'd0);
                end
                model ^= r[exp_idx];
                exp_idx++;
                nxfer++;
            end
            check("skip_done_cycle", {31'd0, done1}, {31'd0, cyc == 48});
        end
        check("skip_xfer_count", nxfer, 31);
        check("skip_csum_model", csum1, model);
        check("skip_csum_zero", csum1, 32'h0000_0000);

        // Backpressure on idx 3 for five cycles
        for (int i = 0; i < 32; i++) r[i] = 32'hA500_0000 + 32'(i);
        run_dump0(3, 1'b0, -1, 54);
        check("stall_word3", r[3], 32'hA500_0003);

        // Start re-pulsed while busy and during DONE
        for (int i = 0; i < 32; i++) r[i] = 32'(i) * 32'h01010101;
        run_dump0(-1, 1'b1, -1, 49);

        // Reset while idx 7 is presented, then a fresh dump
        run_dump0(-1, 1'b0, 7, 0);
        repeat (2) @(negedge clk);
        check_idle0("in_reset");
        n_rst0 = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_valid", {31'd0, if0.out_valid}, 32'd0);
        check("post_reset_busy", {31'd0, busy0}, 32'd0);
        run_dump0(-1, 1'b0, -1, 49);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
